// File: rtl/uge_window_max.sv
// ---------------------------------------------------------------------------
// uge_window_max
//   Streaming window-maximum stage. Takes unsigned samples over a valid/ready
//   handshake and tracks the running maximum with an unsigned >= compare, so a
//   tie replaces the stored value and O_idx names the last occurrence. After
//   WINDOW accepted samples it presents the maximum and its in-window index,
//   and holds them until the consumer takes the result.
//
//   Optional feature (compile-time macro UGE_WINDOW_MAX_OVERLAP_EN):
//     defined   - a new sample may be accepted in the same cycle the held
//                 result transfers, giving 1 sample/cycle sustained.
//     undefined - input is stalled for the whole hold phase, which costs one
//                 bubble cycle per window.
//
// Ports
//   CLK          clock, rising edge
//   ASYNCRESETN  asynchronous active-low reset
//   I            sample data (WIDTH bits, unsigned)
//   I_valid      sample valid
//   I_ready      block can accept a sample (0 while in reset)
//   O            window maximum (keeps the last result until the next window)
//   O_idx        index 0..WINDOW-1 of the reported maximum
//   O_valid      result valid
//   O_ready      consumer accepts the result
// ---------------------------------------------------------------------------
module uge_window_max #(
    parameter int WIDTH  = 2,
    parameter int WINDOW = 4,
    localparam int IDXW  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic [IDXW-1:0]  O_idx,
    output logic             O_valid,
    input  logic             O_ready
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(WINDOW - 1);
    localparam logic [IDXW-1:0]  ONE_IDX  = IDXW'(1);
    localparam logic [IDXW-1:0]  ZERO_IDX = IDXW'(0);
    localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDXW-1:0]  count_r;
    logic [IDXW-1:0]  count_nxt_s;
    logic [WIDTH-1:0] max_r;
    logic [WIDTH-1:0] max_nxt_s;
    logic [IDXW-1:0]  idx_r;
    logic [IDXW-1:0]  idx_nxt_s;
    logic [WIDTH-1:0] o_r;
    logic [WIDTH-1:0] o_nxt_s;
    logic [IDXW-1:0]  o_idx_r;
    logic [IDXW-1:0]  o_idx_nxt_s;
    logic [WIDTH-1:0] cand_max_s;
    logic [IDXW-1:0]  cand_idx_s;
    logic             ready_s;
    logic             accept_s;
    logic             xfer_s;
    logic             last_s;

`ifdef UGE_WINDOW_MAX_OVERLAP_EN
    // The hold slot frees up in the same cycle the consumer takes it.
    assign ready_s = (state_r == ACCUM) | ((state_r == HOLD) & O_ready);
`else
    assign ready_s = (state_r == ACCUM);
`endif

    // Gate with the reset pin so ready drops the instant reset asserts.
    assign I_ready  = ready_s & ASYNCRESETN;
    assign accept_s = I_valid & I_ready;
    assign xfer_s   = (state_r == HOLD) & O_ready;
    assign last_s   = (count_r == LAST_IDX);

    assign O       = o_r;
    assign O_idx   = o_idx_r;
    assign O_valid = (state_r == HOLD);

    // Maximum/index the window would hold if the current sample is accepted.
    // count is 0 whenever a sample lands as index 0 (also in HOLD with overlap).
    always_comb begin
        cand_max_s = max_r;
        cand_idx_s = idx_r;
        if (count_r == ZERO_IDX) begin
            cand_max_s = I;
            cand_idx_s = ZERO_IDX;
        end else if (I >= max_r) begin
            cand_max_s = I;
            cand_idx_s = count_r;
        end else begin
            cand_max_s = max_r;
            cand_idx_s = idx_r;
        end
    end

    // Next-state and datapath update for the window FSM.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        max_nxt_s   = max_r;
        idx_nxt_s   = idx_r;
        o_nxt_s     = o_r;
        o_idx_nxt_s = o_idx_r;
        if (accept_s) begin
            max_nxt_s = cand_max_s;
            idx_nxt_s = cand_idx_s;
            if (last_s) begin
                count_nxt_s = ZERO_IDX;
                state_nxt_s = HOLD;
                o_nxt_s     = cand_max_s;
                o_idx_nxt_s = cand_idx_s;
            end else begin
                count_nxt_s = count_r + ONE_IDX;
                state_nxt_s = ACCUM;
            end
        end else if (xfer_s) begin
            state_nxt_s = ACCUM;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r <= ACCUM;
            count_r <= ZERO_IDX;
            max_r   <= ZERO_VAL;
            idx_r   <= ZERO_IDX;
            o_r     <= ZERO_VAL;
            o_idx_r <= ZERO_IDX;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            max_r   <= max_nxt_s;
            idx_r   <= idx_nxt_s;
            o_r     <= o_nxt_s;
            o_idx_r <= o_idx_nxt_s;
        end
    end

endmodule

// File: tb/tb_uge_window_max.sv
// ---------------------------------------------------------------------------
// tb_uge_window_max
//   Directed bench for uge_window_max (WIDTH=2, WINDOW=4). A table of
//   per-cycle {inputs, expected outputs} rows covers the main function; hand
//   sequences cover reset mid-window / in hold and the throughput stream.
//   Expected outputs are those seen just before the clock edge of each row.
// ---------------------------------------------------------------------------
module tb_uge_window_max;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [1:0] I;
    logic       I_valid;
    logic       I_ready;
    logic [1:0] O;
    logic [1:0] O_idx;
    logic       O_valid;
    logic       O_ready;

    int n_checks;
    int n_fail;

`ifdef UGE_WINDOW_MAX_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic       r;
        logic       ir;
        logic       ov;
        logic [1:0] o;
        logic [1:0] oi;
    } vec_t;

    vec_t tbl[$];

    uge_window_max #(.WIDTH(2), .WINDOW(4)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I          (I),
        .I_valid    (I_valid),
        .I_ready    (I_ready),
        .O          (O),
        .O_idx      (O_idx),
        .O_valid    (O_valid),
        .O_ready    (O_ready)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(input logic v, input logic [1:0] d, input logic r,
                                input logic ir, input logic ov,
                                input logic [1:0] o, input logic [1:0] oi);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.ir = ir; t.ov = ov; t.o = o; t.oi = oi;
        return t;
    endfunction

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(3, 0));
    endfunction

    task automatic cmp(input string tag, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check pre-edge outputs.
    task automatic run_row(input vec_t t, input string tag);
        @(negedge CLK);
        I_valid = t.v;
        I       = t.d;
        O_ready = t.r;
        #1;
        cmp(tag, "I_ready", int'(I_ready), int'(t.ir));
        cmp(tag, "O_valid", int'(O_valid), int'(t.ov));
        cmp(tag, "O",       int'(O),       int'(t.o));
        cmp(tag, "O_idx",   int'(O_idx),   int'(t.oi));
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        I_valid = 1'b0;
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        cmp(tag, "I_ready", int'(I_ready), 0);
        cmp(tag, "O_valid", int'(O_valid), 0);
        cmp(tag, "O",       int'(O),       0);
        cmp(tag, "O_idx",   int'(O_idx),   0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
    endtask

    initial begin
        logic [1:0] stream [8];
        logic [1:0] res_o [$];
        logic [1:0] res_i [$];
        int acc;
        int cyc;
        int used;
        int drops;

        n_checks    = 0;
        n_fail      = 0;
        ASYNCRESETN = 1'b0;
        I_valid     = 1'b1;
        I           = 2'd3;
        O_ready     = 1'b1;

        // Reset state while held in reset.
        #12;
        cmp("reset", "I_ready", int'(I_ready), 0);
        cmp("reset", "O_valid", int'(O_valid), 0);
        cmp("reset", "O",       int'(O),       0);
        cmp("reset", "O_idx",   int'(O_idx),   0);
        I_valid = 1'b0;
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // Window 1,3,0,2 -> max 3 at index 1.
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
        tbl.push_back(mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd3, 2'd1));
        // Window 2,2,1,2 -> tie keeps last occurrence, index 3.
        tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1));
        tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1));
        tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd2, 2'd3));
        // Window 0,0,0,0 -> 0 at index 3.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd3));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd0, 2'd3));
        // Window 3,1,1,1 then consumer stalls 5 cycles while input keeps pushing.
        tbl.push_back(mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1'b1, 2'(k), 1'b0, 1'b0, 1'b1, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        // Valid gaps: 2,x,x,0,x,1,3 -> 3 at index 3.
        tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd3, 2'd3));
        tbl.push_back(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd3, 2'd3));

        foreach (tbl[k]) run_row(tbl[k], $sformatf("row%0d", k));

        // Reset while holding a result: result is lost.
        for (int k = 0; k < 4; k++)
            run_row(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd3), "hold_fill");
        run_row(mk(1'b0, rnd2(), 1'b0, 1'b0, 1'b1, 2'd1, 2'd3), "hold_pre");
        pulse_reset("rst_hold");

        // Reset mid-window after 3,3: partial window discarded.
        run_row(mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "mid_a");
        run_row(mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "mid_b");
        pulse_reset("rst_mid");
        run_row(mk(1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "fresh0");
        run_row(mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "fresh1");
        run_row(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "fresh2");
        run_row(mk(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0), "fresh3");
        run_row(mk(1'b0, rnd2(), 1'b1, OVL, 1'b1, 2'd2, 2'd2), "fresh_out");
        run_row(mk(1'b0, rnd2(), 1'b1, 1'b1, 1'b0, 2'd2, 2'd2), "fresh_idle");

        // Continuous stream of 8 samples with the consumer always ready.
        stream = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
        acc   = 0;
        cyc   = 0;
        used  = 0;
        drops = 0;
        while (cyc < 30 && !(acc == 8 && res_o.size() >= 2)) begin
            @(negedge CLK);
            O_ready = 1'b1;
            if (acc < 8) begin
                I_valid = 1'b1;
                I       = stream[acc];
            end else begin
                I_valid = 1'b0;
            end
            #1;
            if (O_valid) begin
                res_o.push_back(O);
                res_i.push_back(O_idx);
            end
            if (acc < 8 && !I_ready) drops++;
            if (I_valid && I_ready) begin
                acc++;
                if (acc == 8) used = cyc + 1;
            end
            cyc++;
        end
        I_valid = 1'b0;
        cmp("stream", "accepted",  acc,   8);
        cmp("stream", "cycles",    used,  OVL ? 8 : 9);
        cmp("stream", "ready_drop", drops, OVL ? 0 : 1);
        cmp("stream", "results",   res_o.size(), 2);
        if (res_o.size() >= 2) begin
            cmp("stream", "O0",     int'(res_o[0]), 1);
            cmp("stream", "O_idx0", int'(res_i[0]), 0);
            cmp("stream", "O1",     int'(res_o[1]), 2);
            cmp("stream", "O_idx1", int'(res_i[1]), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
